// File: rtl/sap_pkg.sv
// sap_pkg: shared control-word bit indices, opcodes and width defaults for the SAP datapath and controller.
package sap_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;
  localparam int CW_W = 15;
  localparam int C_J = 0, C_CO = 1, C_CE = 2, C_OI = 3, C_BI = 4, C_SU = 5, C_SO = 6, C_AO = 7;
  localparam int C_AI = 8, C_II = 9, C_IO = 10, C_RO = 11, C_RI = 12, C_MI = 13, C_HLT = 14;
  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_LDA = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3, OP_STA = 4'h4, OP_LDI = 4'h5,
    OP_JMP = 4'h6, OP_JC = 4'h7, OP_JZ = 4'h8, OP_OUT = 4'hE, OP_HLT = 4'hF
  } opcode_t;
  function automatic logic multi_hot(input logic [4:0] v);
    return (v & (v - 5'd1)) != 5'd0;
  endfunction
endpackage

// File: rtl/sap_datapath_if.sv
// sap_datapath_if: control word, programming port and status outputs between controller/host and datapath.
interface sap_datapath_if #(parameter int DATA_W = sap_pkg::DATA_W_DEF, parameter int ADDR_W = sap_pkg::ADDR_W_DEF);
  logic [sap_pkg::CW_W-1:0] ctrlwrd;
  logic prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic [3:0] instruction;
  logic [DATA_W-1:0] bus;
  logic [DATA_W-1:0] out_data;
  logic out_valid;
  logic carry;
  logic zero;
  logic halted;
  logic bus_conflict;
  modport master (
    output ctrlwrd, prog_we, prog_addr, prog_data,
    input instruction, bus, out_data, out_valid, carry, zero, halted, bus_conflict
  );
  modport slave (
    input ctrlwrd, prog_we, prog_addr, prog_data,
    output instruction, bus, out_data, out_valid, carry, zero, halted, bus_conflict
  );
endinterface

// File: rtl/sap_alu.sv
// sap_alu: combinational add/subtract on registered A and B with carry-out.
module sap_alu #(parameter int W = 8) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         su,
  output logic [W-1:0] result,
  output logic         carry_out
);
  logic [W:0] sum;
  assign sum = {1'b0, a} + {1'b0, su ? ~b : b} + {{W{1'b0}}, su};
  assign {carry_out, result} = sum;
endmodule

// File: rtl/sap_datapath.sv
// sap_datapath: SAP-1 style bus, registers, RAM, flags and halt logic driven by a 15-bit control word.
module sap_datapath
  import sap_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input logic clk,
  input logic reset,
  sap_datapath_if.slave s
);
  logic [CW_W-1:0] cw;
  logic [ADDR_W-1:0] pc, mar;
  logic [DATA_W-1:0] ir, a, b, out_data, bus, alu_res;
  logic out_valid, carry, zero, halted, alu_co, conflict;
  logic [4:0] drv;
  logic [DATA_W-1:0] ram [2**ADDR_W];
  assign cw = s.ctrlwrd;
  sap_alu #(.W(DATA_W)) u_alu (.a(a), .b(b), .su(cw[C_SU]), .result(alu_res), .carry_out(alu_co));
  always_comb begin
    drv = {cw[C_SO], cw[C_AO], cw[C_RO], cw[C_IO], cw[C_CO]};
    conflict = multi_hot(drv);
    bus = conflict ? '0 :
          cw[C_CO] ? DATA_W'(pc) :
          cw[C_IO] ? DATA_W'(ir[3:0]) :
          cw[C_RO] ? ram[mar] :
          cw[C_AO] ? a :
          cw[C_SO] ? alu_res : '0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= '0;
      mar <= '0;
      ir <= '0;
      a <= '0;
      b <= '0;
      out_data <= '0;
      out_valid <= 1'b0;
      carry <= 1'b0;
      zero <= 1'b0;
      halted <= 1'b0;
    end else begin
      out_valid <= cw[C_OI] && !halted;
      if (cw[C_HLT]) halted <= 1'b1;
      if (!halted) begin
        if (cw[C_J]) pc <= bus[ADDR_W-1:0];
        else if (cw[C_CE]) pc <= pc + ADDR_W'(1);
        if (cw[C_MI]) mar <= bus[ADDR_W-1:0];
        if (cw[C_II]) ir <= bus;
        if (cw[C_AI]) a <= bus;
        if (cw[C_BI]) b <= bus;
        if (cw[C_OI]) out_data <= bus;
        if (cw[C_SO]) begin
          carry <= alu_co;
          zero <= alu_res == '0;
        end
      end
    end
  end
  // RAM is never reset; the programming port always beats a bus write
  always_ff @(posedge clk) begin
    if (s.prog_we) ram[s.prog_addr] <= s.prog_data;
    else if (cw[C_RI] && !halted && !reset) ram[mar] <= bus;
  end
  assign s.instruction = ir[7:4];
  assign s.bus = bus;
  assign s.out_data = out_data;
  assign s.out_valid = out_valid;
  assign s.carry = carry;
  assign s.zero = zero;
  assign s.halted = halted;
  assign s.bus_conflict = conflict;
endmodule

// File: tb/tb_sap_datapath.sv
// tb_sap_datapath: directed and random checks of sap_datapath against an arithmetic reference model.
module tb_sap_datapath;
  import sap_pkg::*;
  localparam logic [14:0] W_J = 15'(1) << C_J, W_CO = 15'(1) << C_CO, W_CE = 15'(1) << C_CE;
  localparam logic [14:0] W_OI = 15'(1) << C_OI, W_BI = 15'(1) << C_BI, W_SU = 15'(1) << C_SU;
  localparam logic [14:0] W_SO = 15'(1) << C_SO, W_AO = 15'(1) << C_AO, W_AI = 15'(1) << C_AI;
  localparam logic [14:0] W_II = 15'(1) << C_II, W_IO = 15'(1) << C_IO, W_RO = 15'(1) << C_RO;
  localparam logic [14:0] W_RI = 15'(1) << C_RI, W_MI = 15'(1) << C_MI, W_HLT = 15'(1) << C_HLT;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;
  sap_datapath_if sif ();
  sap_datapath dut (.clk(clk), .reset(reset), .s(sif));
  always #10 clk = ~clk;
  logic [14:0] cw;
  assign cw = sif.ctrlwrd;
  int m_pc, m_mar, m_ir, m_a, m_b, m_out, nd, alu_s, m_bus;
  logic m_ov, m_c, m_z, m_h;
  int m_ram [16];
  always_comb begin
    nd = int'(cw[C_CO]) + int'(cw[C_IO]) + int'(cw[C_RO]) + int'(cw[C_AO]) + int'(cw[C_SO]);
    alu_s = cw[C_SU] ? m_a + 256 - m_b : m_a + m_b;
    m_bus = nd != 1 ? 0 : cw[C_CO] ? m_pc : cw[C_IO] ? m_ir % 16 : cw[C_RO] ? m_ram[m_mar] :
            cw[C_AO] ? m_a : alu_s % 256;
  end
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc <= 0; m_mar <= 0; m_ir <= 0; m_a <= 0; m_b <= 0; m_out <= 0;
      m_ov <= 0; m_c <= 0; m_z <= 0; m_h <= 0;
    end else begin
      m_ov <= cw[C_OI] && !m_h;
      if (cw[C_HLT]) m_h <= 1;
      if (sif.prog_we) m_ram[sif.prog_addr] <= int'(sif.prog_data);
      else if (cw[C_RI] && !m_h) m_ram[m_mar] <= m_bus;
      if (!m_h) begin
        m_pc <= cw[C_J] ? m_bus % 16 : cw[C_CE] ? (m_pc + 1) % 16 : m_pc;
        if (cw[C_MI]) m_mar <= m_bus % 16;
        if (cw[C_II]) m_ir <= m_bus;
        if (cw[C_AI]) m_a <= m_bus;
        if (cw[C_BI]) m_b <= m_bus;
        if (cw[C_OI]) m_out <= m_bus;
        if (cw[C_SO]) begin
          m_c <= alu_s >= 256;
          m_z <= alu_s % 256 == 0;
        end
      end
    end
  end
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic apply(input logic [14:0] c, input logic we = 1'b0, input logic [3:0] ad = 4'h0, input logic [7:0] d = 8'h0);
    @(negedge clk);
    sif.ctrlwrd = c;
    sif.prog_we = we;
    sif.prog_addr = ad;
    sif.prog_data = d;
    #1;
    chk("bus", sif.bus, 8'(m_bus));
    chk("bus_conflict", 8'(sif.bus_conflict), 8'(nd > 1));
    chk("instruction", 8'(sif.instruction), 8'(m_ir / 16));
    chk("out_data", sif.out_data, 8'(m_out));
    chk("out_valid", 8'(sif.out_valid), 8'(m_ov));
    chk("carry", 8'(sif.carry), 8'(m_c));
    chk("zero", 8'(sif.zero), 8'(m_z));
    chk("halted", 8'(sif.halted), 8'(m_h));
  endtask
  task automatic peek(input logic [14:0] c, input logic [7:0] exp, input string tag);
    apply(c);
    chk(tag, sif.bus, exp);
  endtask
  // MAR is parked at 15 so RAM[15] serves as the staging cell for register loads
  task automatic put(input logic [14:0] dst, input logic [7:0] v);
    apply(15'h0, 1'b1, 4'hF, v);
    apply(dst | W_RO);
  endtask
  initial begin
    sif.ctrlwrd = '0;
    sif.prog_we = 1'b0;
    sif.prog_addr = '0;
    sif.prog_data = '0;
    #1;
    chk("rst_out_data", sif.out_data, 8'h00);
    chk("rst_flags", {4'h0, sif.out_valid, sif.carry, sif.zero, sif.halted}, 8'h00);
    sif.ctrlwrd = W_CO;
    #1 chk("rst_pc", sif.bus, 8'h00);
    sif.ctrlwrd = '0;
    #13 reset = 1'b0;
    for (int i = 0; i < 16; i++) apply(15'h0, 1'b1, 4'(i), 8'($urandom));
    apply(15'h0, 1'b1, 4'h0, 8'h1E);
    apply(15'h0, 1'b1, 4'hE, 8'h05);
    apply(W_CO | W_MI);
    apply(W_RO | W_II | W_CE);
    peek(W_CO, 8'h01, "fetch_pc");
    chk("fetch_opcode", 8'(sif.instruction), 8'h01);
    peek(W_IO, 8'h0E, "fetch_ir_lo");
    apply(15'h0, 1'b1, 4'h0, 8'h0F);
    apply(W_RO | W_MI);
    put(W_AI, 8'h05);
    put(W_BI, 8'h03);
    apply(W_SO | W_AI);
    peek(W_AO, 8'h08, "add_a");
    chk("add_cz", {6'h0, sif.carry, sif.zero}, 8'h00);
    put(W_AI, 8'h03);
    apply(W_SO | W_SU | W_AI);
    peek(W_AO, 8'h00, "sub_a");
    chk("sub_cz", {6'h0, sif.carry, sif.zero}, 8'h03);
    put(W_AI, 8'hFF);
    put(W_BI, 8'h01);
    apply(W_SO | W_AI);
    peek(W_AO, 8'h00, "ovf_a");
    chk("ovf_carry", 8'(sif.carry), 8'h01);
    put(W_J, 8'h0F);
    apply(W_CE);
    peek(W_CO, 8'h00, "pc_wrap");
    apply(W_AO | W_CO);
    chk("conflict_bus", sif.bus, 8'h00);
    chk("conflict_flag", 8'(sif.bus_conflict), 8'h01);
    put(W_II, 8'h67);
    apply(W_IO | W_J | W_CE);
    peek(W_CO, 8'h07, "j_wins");
    put(W_AI, 8'h2A);
    apply(W_AO | W_OI);
    apply(15'h0);
    chk("out_data_2a", sif.out_data, 8'h2A);
    chk("out_valid_hi", 8'(sif.out_valid), 8'h01);
    apply(15'h0);
    chk("out_valid_lo", 8'(sif.out_valid), 8'h00);
    put(W_AI, 8'h33);
    put(W_J, 8'h09);
    apply(W_HLT);
    apply(W_CE | W_AI | W_MI | W_RO);
    chk("halted_set", 8'(sif.halted), 8'h01);
    apply(15'h0, 1'b1, 4'hF, 8'h77);
    peek(W_CO, 8'h09, "halt_pc");
    peek(W_AO, 8'h33, "halt_a");
    peek(W_RO, 8'h77, "halt_prog_we");
    apply(W_AO | W_RI);
    peek(W_RO, 8'h77, "halt_ri_dropped");
    apply(W_AO | W_OI);
    apply(15'h0);
    chk("halt_out_valid", 8'(sif.out_valid), 8'h00);
    chk("halt_out_data", sif.out_data, 8'h2A);
    @(negedge clk);
    sif.ctrlwrd = '0;
    sif.prog_we = 1'b0;
    #2 reset = 1'b1;
    #1 chk("mid_rst_flags", {4'h0, sif.out_valid, sif.carry, sif.zero, sif.halted}, 8'h00);
    chk("mid_rst_out", sif.out_data, 8'h00);
    chk("mid_rst_ir", 8'(sif.instruction), 8'h00);
    sif.ctrlwrd = W_CO;
    #1 chk("mid_rst_pc", sif.bus, 8'h00);
    sif.ctrlwrd = W_AO;
    #1 chk("mid_rst_a", sif.bus, 8'h00);
    sif.ctrlwrd = W_SO;
    #1 chk("mid_rst_alu", sif.bus, 8'h00);
    sif.ctrlwrd = W_IO;
    #1 chk("mid_rst_ir_lo", sif.bus, 8'h00);
    sif.ctrlwrd = '0;
    #1 reset = 1'b0;
    apply(15'h0, 1'b1, 4'h0, 8'h0E);
    apply(W_RO | W_MI);
    peek(W_RO, 8'h05, "ram_kept");
    for (int i = 0; i < 300; i++)
      apply(15'($urandom) & ~W_HLT, $urandom_range(0, 3) == 0, 4'($urandom), 8'($urandom));
    apply(W_HLT);
    for (int i = 0; i < 30; i++)
      apply(15'($urandom), $urandom_range(0, 3) == 0, 4'($urandom), 8'($urandom));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
